bcd2bin: RTL and testbench
==========================

Name: bcd2bin

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It is the inverse of the existing binary-to-BCD unit. It converts packed BCD digits, such as a thumbwheel or keypad-entered ms threshold, into a binary count that timer/comparator logic can use. Its start/ready/done_tick handshake matches the binary-to-BCD unit, so the two can sit on the same control FSM.

Parameters:
DIGITS, 4, number of packed BCD input digits (1..6)
BIN_W, 14, binary output width; must be >= ceil(log2(10^DIGITS)); 14 covers 0..9999

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request conversion; sampled only in idle
bcd  input  4*DIGITS  packed BCD, bcd[3:0] = least significant digit; sampled on the accepting edge only
ready  output  1  high while in idle (start will be accepted)
done_tick  output  1  one-cycle pulse: result valid
bin  output  BIN_W  registered result; holds last value until next done_tick
err  output  1  registered invalid-digit flag (only with the optional feature; otherwise tied 0)

Behaviour:
- Reset (reset_n low, asynchronous): state=idle, ready=1, done_tick=0, bin=0, err=0, internal shift regs and counter=0.
- Datapath: bcd_reg (4*DIGITS bits), acc_reg (4*DIGITS bits), iteration counter n (width clog2(4*DIGITS)+1).
- States: idle, op, done.
- idle: ready=1.
  - start=1 → load bcd_reg<=bcd, acc_reg<=0, n<=4*DIGITS, go to op.
  - start=0 → stay in idle.
- op: ready=0. Each cycle:
  - {bcd_reg,acc_reg} <= ({bcd_reg,acc_reg} >> 1);
  - then every 4-bit digit of the shifted bcd_reg that is >=8 gets 3 subtracted (same cycle, combinational before the register);
  - n<=n-1.
  - When n==1 on this edge (last shift), go to done.
- done: ready=0, done_tick=1 for exactly this cycle. bin <= acc_reg[BIN_W-1:0] is registered on the edge entering done, so it is valid while done_tick is high. Next state idle.
- Latency:
  - start sampled at edge k → 4*DIGITS shifts on edges k+1..k+4*DIGITS;
  - done_tick high from edge k+4*DIGITS to k+4*DIGITS+1;
  - ready returns high after edge k+4*DIGITS+1.
  - For DIGITS=4: done_tick is 16 cycles after acceptance. Back-to-back conversion period is 18 cycles.
- start while in op or done is ignored. bcd changes after acceptance have no effect.
- bin and err change only on the edge entering done; they are stable in idle and op.
- Truncation: upper acc bits above BIN_W are discarded. This is not an error; it is a parameter-constraint violation by the integrator.
- Reset asserted mid-op: conversion is aborted and all outputs return to their reset values; no done_tick is produced.

Optional Feature:
Macro BCD2BIN_CHECK_EN.
- Defined: on the accepting edge, any input digit >9 sets a pending flag.
  - The conversion still runs the full latency, so timing is unchanged.
  - At done: err<=1 and bin<=0.
  - For a valid input: err<=0 and bin<=result.
- Undefined: no check logic; err is constant 0. Invalid digits run through the algorithm unmodified, giving a deterministic but meaningless bin.

Test Plan:
- Reset then bcd=16'h9999, start for 1 cycle → ready drops next cycle; done_tick exactly 16 cycles after the accepting edge; bin=9999 (14'h270F); err=0.
- bcd=16'h0000 → bin=0. Then bcd=16'h0010 → bin=10. Then bcd=16'h1234 → bin=1234 (14'h04D2). Each case: exactly one done_tick; ready high again the cycle after done.
- Accept bcd=16'h0500, then pulse start with bcd=16'h9999 at cycles 3 and 10 of op → single done_tick, bin=500, no second conversion starts.
- Complete a conversion to bin=1234, then start with 16'h0042 and assert reset_n low at op cycle 8 → bin=0, ready=1, done_tick never pulses. After release, new start with 16'h0042 → bin=42.
- With BCD2BIN_CHECK_EN defined: bcd=16'h12A4 → done_tick at 16 cycles, err=1, bin=0. Next bcd=16'h0777 → err=0, bin=777.
- Sweep DIGITS=2, BIN_W=7 over all 100 valid inputs → bin equals the decimal value; done_tick 8 cycles after acceptance.

Source files
------------

// File: rtl/bcd2bin_if.sv
// ----------------------------------------------------------------------------
// bcd2bin_if
//   Start/ready/done_tick handshake and data bus of the BCD-to-binary
//   converter. Same handshake shape as the binary-to-BCD unit, so both can be
//   sequenced by one control FSM.
//
//   Handshake: the master raises start with bcd valid; the request is
//   accepted on the rising clk edge where start=1 and ready=1, and bcd is
//   sampled on that edge only. start while ready=0 is ignored, not queued.
//   done_tick is a one-cycle pulse; bin/err are valid while it is high and
//   hold their value until the next done_tick.
//
//   Signals:
//     start     master -> slave  request a conversion
//     bcd       master -> slave  packed BCD, bcd[3:0] = least significant digit
//     ready     slave  -> master converter idle, start will be accepted
//     done_tick slave  -> master one-cycle result-valid pulse
//     bin       slave  -> master binary result
//     err       slave  -> master invalid-digit flag (0 unless BCD2BIN_CHECK_EN)
// ----------------------------------------------------------------------------
interface bcd2bin_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ready;
    logic                  done_tick;
    logic [BIN_W-1:0]      bin;
    logic                  err;

    modport master (
        output start,
        output bcd,
        input  ready,
        input  done_tick,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  bcd,
        output ready,
        output done_tick,
        output bin,
        output err
    );
endinterface

// File: rtl/bcd2bin.sv
// ----------------------------------------------------------------------------
// bcd2bin
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   Every op cycle the {bcd_reg, acc_reg} pair shifts right by one bit, then
//   each 4-bit digit of the shifted BCD half that is >= 8 has 3 subtracted.
//   After 4*DIGITS shifts acc_reg holds the binary value.
//
//   Timing (start accepted on edge k):
//     shifts on edges k+1 .. k+4*DIGITS, done_tick high for the cycle after
//     edge k+4*DIGITS, ready high again after edge k+4*DIGITS+1.
//
//   Optional feature, macro BCD2BIN_CHECK_EN:
//     defined   - any input digit > 9 on the accepting edge makes the
//                 conversion finish with err=1, bin=0 (latency unchanged).
//     undefined - no check; err is constant 0.
//
//   Ports:
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     bus        bcd2bin_if.slave (start, bcd, ready, done_tick, bin, err)
//     dbg_state  current FSM state (0=idle, 1=op, 2=done)
//
//   Parameters:
//     DIGITS  number of packed BCD digits (1..6)
//     BIN_W   result width, must be >= ceil(log2(10^DIGITS)); wider
//             accumulator bits are discarded
// ----------------------------------------------------------------------------
module bcd2bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic        clk,
    input  logic        reset_n,
    bcd2bin_if.slave    bus,
    output logic [1:0]  dbg_state
);

    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [W-1:0]      bcd_reg;
    logic [W-1:0]      acc_reg;
    logic [NW-1:0]     n;
    logic              ready_q;
    logic              done_q;
    logic [BIN_W-1:0]  bin_q;

    // ------------------------------------------------------------------
    // One reverse double-dabble step: shift the pair right, then correct
    // the BCD half. A digit >= 8 after the shift means it received a 1
    // from the digit above (worth 10/2 = 5 here, but 8 in binary), so 3
    // is removed to restore decimal weighting.
    // ------------------------------------------------------------------
    logic [2*W-1:0]    shifted;
    logic [W-1:0]      bcd_fix;
    logic [W-1:0]      acc_next;
    logic [BIN_W-1:0]  result;

    always_comb begin
        shifted  = {bcd_reg, acc_reg} >> 1;
        acc_next = shifted[W-1:0];
        bcd_fix  = shifted[2*W-1:W];
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_fix[4*d+3]) begin
                bcd_fix[4*d +: 4] = bcd_fix[4*d +: 4] - 4'd3;
            end
        end
        result = BIN_W'(acc_next);
    end

`ifdef BCD2BIN_CHECK_EN
    logic any_bad;
    logic pend;
    logic err_q;

    always_comb begin
        any_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bus.bcd[4*d +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM and datapath registers. All outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bin_q   <= '0;
            bcd_reg <= '0;
            acc_reg <= '0;
            n       <= '0;
`ifdef BCD2BIN_CHECK_EN
            pend    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bcd_reg <= bus.bcd;
                        acc_reg <= '0;
                        n       <= NW'(W);
                        ready_q <= 1'b0;
                        state   <= S_OP;
`ifdef BCD2BIN_CHECK_EN
                        pend    <= any_bad;
`endif
                    end
                end

                S_OP: begin
                    bcd_reg <= bcd_fix;
                    acc_reg <= acc_next;
                    n       <= n - 1'b1;
                    // n==1 means this edge performs the final shift, so the
                    // result is captured from the combinational step output.
                    if (n == NW'(1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
                        if (pend) begin
                            err_q <= 1'b1;
                            bin_q <= '0;
                        end else begin
                            err_q <= 1'b0;
                            bin_q <= result;
                        end
`else
                        bin_q  <= result;
`endif
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end

                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done_tick = done_q;
    assign bus.bin       = bin_q;
`ifdef BCD2BIN_CHECK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
    assign dbg_state     = state;

endmodule

// File: tb/tb_bcd2bin.sv
// ----------------------------------------------------------------------------
// tb_bcd2bin
//   Bench for bcd2bin: a 4-digit/14-bit instance for the main tests and a
//   2-digit/7-bit instance for the full valid-input sweep. Expected results
//   come from a decimal-arithmetic model (sum of digit * 10^i, truncated to
//   BIN_W) and from constant tables. Define BCD2BIN_CHECK_EN to exercise the
//   invalid-digit flag as well.
// ----------------------------------------------------------------------------
module tb_bcd2bin;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bcd2bin_if #(.DIGITS(4), .BIN_W(14)) bus4 ();
    bcd2bin_if #(.DIGITS(2), .BIN_W(7))  bus2 ();
    logic [1:0] dbg4;
    logic [1:0] dbg2;

    bcd2bin #(.DIGITS(4), .BIN_W(14)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus4),
        .dbg_state (dbg4)
    );

    bcd2bin #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus2),
        .dbg_state (dbg2)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_fail = 0;
    int ticks4 = 0;
    int ticks2 = 0;
    logic [14:0] exp_q[$];   // {err, bin} for the 4-digit instance
    logic [7:0]  exp_q2[$];  // {err, bin} for the 2-digit instance

    always @(negedge clk) begin
        if (bus4.done_tick) ticks4++;
        if (bus2.done_tick) ticks2++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_val(input logic [23:0] v, input int digits, input int binw);
        longint val = 0;
        for (int i = digits - 1; i >= 0; i--) val = val * 10 + longint'(v[4*i +: 4]);
        return 32'(val % (longint'(1) << binw));
    endfunction

    function automatic logic bad_digit(input logic [23:0] v, input int digits);
        logic b = 1'b0;
        for (int i = 0; i < digits; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic convert4(input logic [15:0] v, output logic [13:0] got_bin, output logic got_err);
        int lat;
        int t0;
        logic [14:0] exp;
        exp = {1'b0, 14'(model_val({8'h00, v}, 4, 14))};
`ifdef BCD2BIN_CHECK_EN
        if (bad_digit({8'h00, v}, 4)) exp = {1'b1, 14'd0};
`endif
        exp_q.push_back(exp);
        got_bin = '0;
        got_err = 1'b0;
        @(negedge clk);
        chk("ready_idle4", 32'(bus4.ready), 32'd1);
        t0 = ticks4;
        bus4.bcd   = v;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.bcd   = 16'($urandom);   // must not disturb the running conversion
        chk("ready_drop4", 32'(bus4.ready), 32'd0);
        lat = 0;
        while (!bus4.done_tick && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus4.done_tick) begin
            chk("done_timeout4", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        chk("latency4", 32'(lat), 32'd16);
        got_bin = bus4.bin;
        got_err = bus4.err;
        exp = exp_q.pop_front();
        chk("sb_bin4", 32'(got_bin), 32'(exp[13:0]));
        chk("sb_err4", 32'(got_err), 32'(exp[14]));
        @(negedge clk);
        chk("done_one_cycle4", 32'(bus4.done_tick), 32'd0);
        chk("ready_back4", 32'(bus4.ready), 32'd1);
        chk("tick_count4", 32'(ticks4 - t0), 32'd1);
        chk("bin_hold4", 32'(bus4.bin), 32'(exp[13:0]));
    endtask

    task automatic convert2(input logic [7:0] v, output logic [6:0] got_bin);
        int lat;
        logic [7:0] exp;
        exp = {1'b0, 7'(model_val({16'h0000, v}, 2, 7))};
        exp_q2.push_back(exp);
        got_bin = '0;
        @(negedge clk);
        chk("ready_idle2", 32'(bus2.ready), 32'd1);
        bus2.bcd   = v;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        lat = 0;
        while (!bus2.done_tick && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus2.done_tick) begin
            chk("done_timeout2", 32'd0, 32'd1);
            void'(exp_q2.pop_front());
            return;
        end
        chk("latency2", 32'(lat), 32'd8);
        got_bin = bus2.bin;
        exp = exp_q2.pop_front();
        chk("sb_bin2", 32'(got_bin), 32'(exp[6:0]));
        chk("sb_err2", 32'(bus2.err), 32'(exp[7]));
        @(negedge clk);
        chk("ready_back2", 32'(bus2.ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] bcd;
        logic [13:0] exp_bin;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [13:0] b;
        logic        e;
        logic [6:0]  b2;
        logic [15:0] v;
        int          lat;
        int          t0;
        int          t2;

        tbl.push_back('{16'h9999, 14'h270F, 1'b0});
        tbl.push_back('{16'h0000, 14'd0,    1'b0});
        tbl.push_back('{16'h0010, 14'd10,   1'b0});
        tbl.push_back('{16'h1234, 14'h04D2, 1'b0});
`ifdef BCD2BIN_CHECK_EN
        tbl.push_back('{16'h12A4, 14'd0,    1'b1});
`endif
        tbl.push_back('{16'h0777, 14'd777,  1'b0});
        tbl.push_back('{16'h0042, 14'd42,   1'b0});
        tbl.push_back('{16'h9990, 14'd9990, 1'b0});

        reset_n    = 1'b0;
        bus4.start = 1'b0;
        bus4.bcd   = '0;
        bus2.start = 1'b0;
        bus2.bcd   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_ready", 32'(bus4.ready), 32'd1);
        chk("rst_done", 32'(bus4.done_tick), 32'd0);
        chk("rst_bin", 32'(bus4.bin), 32'd0);
        chk("rst_err", 32'(bus4.err), 32'd0);
        chk("rst_state", 32'(dbg4), 32'd0);
        chk("rst_bin2", 32'(bus2.bin), 32'd0);

        // table vectors
        foreach (tbl[i]) begin
            convert4(tbl[i].bcd, b, e);
            chk("tbl_bin", 32'(b), 32'(tbl[i].exp_bin));
            chk("tbl_err", 32'(e), 32'(tbl[i].exp_err));
        end

        // start during op is ignored
        t0 = ticks4;
        @(negedge clk);
        bus4.bcd   = 16'h0500;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.bcd   = 16'h9999;
        lat = 0;
        while (!bus4.done_tick && lat < 40) begin
            @(negedge clk);
            lat++;
            bus4.start = (lat == 2 || lat == 9);
        end
        bus4.start = 1'b0;
        chk("ign_done_seen", 32'(bus4.done_tick), 32'd1);
        chk("ign_latency", 32'(lat), 32'd16);
        chk("ign_bin", 32'(bus4.bin), 32'd500);
        repeat (25) @(negedge clk);
        chk("ign_ticks", 32'(ticks4 - t0), 32'd1);
        chk("ign_ready", 32'(bus4.ready), 32'd1);
        chk("ign_state", 32'(dbg4), 32'd0);

        // reset in the middle of a conversion
        convert4(16'h1234, b, e);
        chk("pre_rst_bin", 32'(b), 32'd1234);
        t0 = ticks4;
        t2 = ticks2;
        @(negedge clk);
        bus4.bcd   = 16'h0042;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_bin", 32'(bus4.bin), 32'd0);
        chk("abort_ready", 32'(bus4.ready), 32'd1);
        chk("abort_done", 32'(bus4.done_tick), 32'd0);
        chk("abort_err", 32'(bus4.err), 32'd0);
        chk("abort_state", 32'(dbg4), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_tick", 32'(ticks4 - t0), 32'd0);
        chk("abort_no_tick2", 32'(ticks2 - t2), 32'd0);
        chk("abort_ready_after", 32'(bus4.ready), 32'd1);
        convert4(16'h0042, b, e);
        chk("post_rst_bin", 32'(b), 32'd42);

        // randomized conversions against the model
        for (int r = 0; r < 30; r++) begin
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD2BIN_CHECK_EN
            if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
`endif
            convert4(v, b, e);
        end

        // full sweep of the 2-digit instance
        for (int i = 0; i < 100; i++) begin
            convert2({4'(i / 10), 4'(i % 10)}, b2);
            chk("sweep2", 32'(b2), 32'(i));
        end

        chk("sb_drained", 32'(exp_q.size() + exp_q2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
